pipeline_controller: RTL and testbench

Hazard and stall controller for the 5-stage 20-bit pipeline. It inspects the instructions held in IF/ID and ID/EX, the branch outcome from EX, and the data-memory handshake, and drives the write-enable, flush, bubble and hold controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also provides a memory-wait watchdog and a stall-cycle counter for performance debug.

---
 rtl/pipeline_pkg.sv | 29 ++
 rtl/pipeline_controller_if.sv | 32 +++
 rtl/pipeline_controller_hazard_detect.sv | 32 +++
 rtl/pipeline_controller.sv | 134 +++++++++++++
 tb/tb_pipeline_controller.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings for the 5-stage 20-bit pipeline controller:
// opcodes, instruction field positions and the controller state enum.
package pipeline_pkg;

  localparam int INSTR_W  = 20;
  localparam int FIELD_W  = 4;
  localparam int OP_LSB   = 16;
  localparam int DEST_LSB = 12;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 4;

  localparam logic [FIELD_W-1:0] OP_NOP = 4'h0;
  localparam logic [FIELD_W-1:0] OP_LW  = 4'h1;
  localparam logic [FIELD_W-1:0] OP_SW  = 4'h2;
  localparam logic [FIELD_W-1:0] OP_BEQ = 4'h3;
  localparam logic [FIELD_W-1:0] OP_J   = 4'h4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  function automatic logic [FIELD_W-1:0] get_field(input logic [INSTR_W-1:0] instr,
                                                   input int lsb);
    return instr[lsb +: FIELD_W];
  endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// Hazard-controller bundle: instruction/branch/memory status in, pipeline
// register controls and debug status out.
interface pipeline_controller_if;
  import pipeline_pkg::*;

  logic [INSTR_W-1:0] id_instruction;
  logic [INSTR_W-1:0] ex_instruction;
  logic               branch_taken;
  logic               mem_req;
  logic               mem_ready;
  logic               pc_write;
  logic               if_id_write;
  logic               if_id_flush;
  logic               id_ex_bubble;
  logic               pipe_hold;
  logic               mem_wb_bubble;
  logic               halted;
  logic [15:0]        stall_count;

  modport master (
    output id_instruction, ex_instruction, branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
           mem_wb_bubble, halted, stall_count
  );

  modport slave (
    input  id_instruction, ex_instruction, branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
           mem_wb_bubble, halted, stall_count
  );

endinterface

// File: rtl/pipeline_controller_hazard_detect.sv
// Combinational load-use detector: flags an ID instruction that reads the
// destination of a load currently in EX.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [INSTR_W-1:0] id_instr_i,
  input  logic [INSTR_W-1:0] ex_instr_i,
  output logic               load_use_o
);

  logic [FIELD_W-1:0] id_op, id_src1, id_src2, ex_op, ex_dest;
  logic               reads_src1, reads_src2;
  logic               unused_bits;

  assign id_op   = get_field(id_instr_i, OP_LSB);
  assign id_src1 = get_field(id_instr_i, SRC1_LSB);
  assign id_src2 = get_field(id_instr_i, SRC2_LSB);
  assign ex_op   = get_field(ex_instr_i, OP_LSB);
  assign ex_dest = get_field(ex_instr_i, DEST_LSB);

  assign unused_bits = ^{id_instr_i[15:12], id_instr_i[3:0], ex_instr_i[11:0]};

  always_comb begin
    reads_src1 = (id_op != OP_NOP) && (id_op != OP_J);
    // LW reads only its base register; everything else that reads src1 also reads src2.
    reads_src2 = reads_src1 && (id_op != OP_LW);
    load_use_o = (ex_op == OP_LW) && (ex_dest != '0) &&
                 ((reads_src1 && (id_src1 == ex_dest)) ||
                  (reads_src2 && (id_src2 == ex_dest)));
  end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline hazard/stall controller: RUN/MEM_WAIT/HALT FSM with a memory-wait
// watchdog and a saturating stall-cycle counter.
module pipeline_controller
  import pipeline_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  pipeline_controller_if.slave ctl
);

  localparam int WCNT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_WAIT - 1);

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0]        stall_count_q, stall_count_d;

  logic load_use, taken, run_rules;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic pipe_hold, mem_wb_bubble, halted;

  hazard_detect u_hazard (
    .id_instr_i (ctl.id_instruction),
    .ex_instr_i (ctl.ex_instruction),
    .load_use_o (load_use)
  );

  assign taken = ctl.branch_taken &&
                 ((get_field(ctl.ex_instruction, OP_LSB) == OP_BEQ) ||
                  (get_field(ctl.ex_instruction, OP_LSB) == OP_J));

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    pipe_hold     = 1'b0;
    mem_wb_bubble = 1'b0;
    halted        = 1'b0;
    run_rules     = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;

    unique case (state_q)
      RUN: begin
        if (ctl.mem_req && !ctl.mem_ready) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          pipe_hold     = 1'b1;
          mem_wb_bubble = 1'b1;
          state_d       = MEM_WAIT;
          wait_cnt_d    = WCNT_W'(1);
        end else begin
          run_rules  = 1'b1;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (!ctl.mem_ready) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          pipe_hold     = 1'b1;
          mem_wb_bubble = 1'b1;
          if (wait_cnt_q == WAIT_LAST) state_d = HALT;
          else                         wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
          run_rules  = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      HALT: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        pipe_hold     = 1'b1;
        mem_wb_bubble = 1'b1;
        halted        = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    // A taken branch squashes the younger instructions, so any load-use on them is moot.
    if (run_rules) begin
      if (taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_use) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end

    if (!reset) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      pipe_hold     = 1'b0;
      mem_wb_bubble = 1'b1;
      halted        = 1'b0;
    end

    stall_count_d = stall_count_q;
    if (!pc_write && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ctl.pc_write      = pc_write;
  assign ctl.if_id_write   = if_id_write;
  assign ctl.if_id_flush   = if_id_flush;
  assign ctl.id_ex_bubble  = id_ex_bubble;
  assign ctl.pipe_hold     = pipe_hold;
  assign ctl.mem_wb_bubble = mem_wb_bubble;
  assign ctl.halted        = halted;
  assign ctl.stall_count   = stall_count_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: a default-depth instance for hazard
// and memory-wait behaviour, and a MAX_WAIT=4 instance for watchdog/saturation.
module tb_pipeline_controller;
  import pipeline_pkg::*;

  // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_wb_bubble, halted}
  localparam logic [6:0] V_RUN   = 7'b1100000;
  localparam logic [6:0] V_LU    = 7'b0001000;
  localparam logic [6:0] V_BR    = 7'b1111000;
  localparam logic [6:0] V_STALL = 7'b0000110;
  localparam logic [6:0] V_HALT  = 7'b0000111;
  localparam logic [6:0] V_RST   = 7'b0011010;
  localparam logic [3:0] OP_ALU  = 4'h5;
  localparam logic [3:0] OP_ALU2 = 4'h6;

  logic clock = 1'b0;
  logic rst_m, rst_w;
  int   checks   = 0;
  int   failures = 0;

  pipeline_controller_if mif ();
  pipeline_controller_if wif ();

  pipeline_controller #(.MAX_WAIT(16)) dut_m (.clock(clock), .reset(rst_m), .ctl(mif));
  pipeline_controller #(.MAX_WAIT(4))  dut_w (.clock(clock), .reset(rst_w), .ctl(wif));

  always #5 clock = ~clock;

  function automatic logic [19:0] mk(input logic [3:0] op, input logic [3:0] d,
                                     input logic [3:0] s1, input logic [3:0] s2);
    return {op, d, s1, s2, 4'h0};
  endfunction

  function automatic logic [6:0] vm();
    return {mif.pc_write, mif.if_id_write, mif.if_id_flush, mif.id_ex_bubble,
            mif.pipe_hold, mif.mem_wb_bubble, mif.halted};
  endfunction

  function automatic logic [6:0] vw();
    return {wif.pc_write, wif.if_id_write, wif.if_id_flush, wif.id_ex_bubble,
            wif.pipe_hold, wif.mem_wb_bubble, wif.halted};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_m(input logic [19:0] id, input logic [19:0] ex, input logic br,
                         input logic req, input logic rdy);
    mif.id_instruction = id;
    mif.ex_instruction = ex;
    mif.branch_taken   = br;
    mif.mem_req        = req;
    mif.mem_ready      = rdy;
  endtask

  // Check main-instance outputs for the current cycle, then advance one edge.
  task automatic expect_m(input string tag, input logic [6:0] v);
    #1;
    chk(tag, 32'(vm()), 32'(v));
    step();
  endtask

  task automatic expect_w(input string tag, input logic [6:0] v);
    #1;
    chk(tag, 32'(vw()), 32'(v));
    step();
  endtask

  initial begin
    rst_m = 1'b0;
    rst_w = 1'b0;
    drive_m('0, '0, 1'b0, 1'b0, 1'b0);
    wif.id_instruction = '0;
    wif.ex_instruction = '0;
    wif.branch_taken   = 1'b0;
    wif.mem_req        = 1'b0;
    wif.mem_ready      = 1'b0;

    // Reset: forced outputs, memory request ignored, counter cleared
    #2;
    chk("rst_outputs", 32'(vm()), 32'(V_RST));
    step();
    chk("rst_count", 32'(mif.stall_count), 32'd0);
    drive_m('0, '0, 1'b0, 1'b1, 1'b0);
    expect_m("rst_with_memreq", V_RST);
    chk("rst_count_hold", 32'(mif.stall_count), 32'd0);
    drive_m('0, '0, 1'b0, 1'b0, 1'b0);
    rst_m = 1'b1;
    #1;
    chk("run_idle", 32'(vm()), 32'(V_RUN));

    // Load-use on src1: exactly one bubble
    drive_m(mk(OP_ALU, 4'h1, 4'h3, 4'h2), mk(OP_LW, 4'h3, 4'h0, 4'h0), 1'b0, 1'b0, 1'b0);
    expect_m("lu_src1", V_LU);
    drive_m(mk(OP_ALU, 4'h1, 4'h3, 4'h2), mk(OP_NOP, 4'h0, 4'h0, 4'h0), 1'b0, 1'b0, 1'b0);
    expect_m("lu_release", V_RUN);
    chk("lu_count", 32'(mif.stall_count), 32'd1);

    // No hazard: dest 0, and J reads no sources
    drive_m(mk(OP_ALU, 4'h1, 4'h0, 4'h0), mk(OP_LW, 4'h0, 4'h2, 4'h0), 1'b0, 1'b0, 1'b0);
    expect_m("lu_dest0", V_RUN);
    drive_m(mk(OP_J, 4'h0, 4'h5, 4'h5), mk(OP_LW, 4'h5, 4'h2, 4'h0), 1'b0, 1'b0, 1'b0);
    expect_m("lu_jump", V_RUN);

    // src2 match: SW reads src2, LW does not
    drive_m(mk(OP_SW, 4'h0, 4'h1, 4'h7), mk(OP_LW, 4'h7, 4'h2, 4'h0), 1'b0, 1'b0, 1'b0);
    expect_m("lu_sw_src2", V_LU);
    drive_m(mk(OP_LW, 4'h2, 4'h1, 4'h7), mk(OP_LW, 4'h7, 4'h2, 4'h0), 1'b0, 1'b0, 1'b0);
    expect_m("lu_lw_nosrc2", V_RUN);
    chk("lu_count2", 32'(mif.stall_count), 32'd2);

    // Branches: taken BEQ/J flush; branch_taken is qualified by the EX opcode
    drive_m(mk(OP_ALU, 4'h1, 4'h4, 4'h4), mk(OP_BEQ, 4'h4, 4'h1, 4'h2), 1'b1, 1'b0, 1'b0);
    expect_m("br_beq_taken", V_BR);
    drive_m(mk(OP_ALU, 4'h1, 4'h4, 4'h4), mk(OP_ALU2, 4'h4, 4'h1, 4'h2), 1'b1, 1'b0, 1'b0);
    expect_m("br_not_branch_op", V_RUN);
    drive_m(mk(OP_NOP, 4'h0, 4'h0, 4'h0), mk(OP_J, 4'h0, 4'h0, 4'h0), 1'b1, 1'b0, 1'b0);
    expect_m("br_j_taken", V_BR);
    drive_m(mk(OP_ALU, 4'h1, 4'h4, 4'h4), mk(OP_BEQ, 4'h4, 4'h1, 4'h2), 1'b0, 1'b0, 1'b0);
    expect_m("br_beq_not_taken", V_RUN);
    chk("br_count", 32'(mif.stall_count), 32'd2);

    // Fresh counter for the memory-wait sequence
    rst_m = 1'b0;
    drive_m('0, '0, 1'b0, 1'b0, 1'b0);
    expect_m("rst2_outputs", V_RST);
    rst_m = 1'b1;
    #1;
    chk("rst2_count", 32'(mif.stall_count), 32'd0);

    // Memory wait: 4 not-ready cycles (RUN + 3 in MEM_WAIT), then ready
    drive_m('0, '0, 1'b0, 1'b1, 1'b0);
    expect_m("mw_run_cycle", V_STALL);
    expect_m("mw_wait1", V_STALL);
    drive_m(mk(OP_ALU, 4'h1, 4'h2, 4'h3), mk(OP_BEQ, 4'h0, 4'h1, 4'h2), 1'b1, 1'b1, 1'b0);
    expect_m("mw_wait2_branch_ignored", V_STALL);
    drive_m('0, '0, 1'b0, 1'b1, 1'b0);
    expect_m("mw_wait3", V_STALL);
    drive_m('0, '0, 1'b0, 1'b1, 1'b1);
    expect_m("mw_ready", V_RUN);
    drive_m('0, '0, 1'b0, 1'b0, 1'b0);
    expect_m("mw_back_to_run", V_RUN);
    chk("mw_count", 32'(mif.stall_count), 32'd4);

    // Ready in the same cycle as the request: no stall
    drive_m('0, '0, 1'b0, 1'b1, 1'b1);
    expect_m("mw_same_cycle_ready", V_RUN);
    chk("mw_same_cycle_count", 32'(mif.stall_count), 32'd4);

    // Ready in MEM_WAIT applies RUN rules: taken jump flushes
    drive_m('0, '0, 1'b0, 1'b1, 1'b0);
    expect_m("mw2_stall", V_STALL);
    drive_m('0, mk(OP_J, 4'h0, 4'h0, 4'h0), 1'b1, 1'b1, 1'b1);
    expect_m("mw2_ready_branch", V_BR);
    drive_m('0, '0, 1'b0, 1'b0, 1'b0);
    expect_m("mw2_run", V_RUN);
    chk("mw2_count", 32'(mif.stall_count), 32'd5);

    // Watchdog (MAX_WAIT=4): four not-ready cycles, then HALT
    step();
    rst_w = 1'b1;
    wif.mem_req   = 1'b1;
    wif.mem_ready = 1'b0;
    expect_w("wd_nr1", V_STALL);
    expect_w("wd_nr2", V_STALL);
    expect_w("wd_nr3", V_STALL);
    expect_w("wd_nr4", V_STALL);
    #1;
    chk("wd_halted", 32'(vw()), 32'(V_HALT));
    chk("wd_count", 32'(wif.stall_count), 32'd4);
    wif.mem_ready = 1'b1;
    expect_w("wd_halt_sticky", V_HALT);
    chk("wd_count_halt", 32'(wif.stall_count), 32'd5);
    rst_w = 1'b0;
    wif.mem_req   = 1'b0;
    wif.mem_ready = 1'b0;
    expect_w("wd_reset_outputs", V_RST);
    rst_w = 1'b1;
    #1;
    chk("wd_after_reset", 32'(vw()), 32'(V_RUN));
    chk("wd_after_reset_count", 32'(wif.stall_count), 32'd0);

    // Saturation: 70000 stall cycles via a held-off memory access
    wif.mem_req = 1'b1;
    repeat (65534) step();
    chk("sat_fffe", 32'(wif.stall_count), 32'hFFFE);
    step();
    chk("sat_ffff", 32'(wif.stall_count), 32'hFFFF);
    repeat (4465) step();
    chk("sat_hold", 32'(wif.stall_count), 32'hFFFF);
    chk("sat_halted", 32'(vw()), 32'(V_HALT));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
